// File: rtl/iwdg_kick_master.sv
// Wishbone master that programs the IWDG (unlock, PR, RLR, start) and then keeps refreshing it.
// Define IWDG_KICK_VERIFY_EN to read the reload register back before starting the watchdog.
module iwdg_kick_master #(
  parameter int          IWDG_KR_SIZE  = 16,
  parameter int          IWDG_PR_SIZE  = 3,
  parameter int          IWDG_RLR_SIZE = 12,
  parameter int          PERIOD_SIZE   = 16,
  parameter int          ACK_TIMEOUT   = 16,
  parameter logic [31:0] BASE_ADR      = 32'h0100_0000,
  parameter logic [31:0] IWDG_KR_ADR   = BASE_ADR + 32'h0,
  parameter logic [31:0] IWDG_PR_ADR   = BASE_ADR + 32'h4,
  parameter logic [31:0] IWDG_RLR_ADR  = BASE_ADR + 32'h8
) (
  input  logic                     clk_m2s,
  input  logic                     rst_m2s,
  input  logic                     start,
  input  logic [IWDG_PR_SIZE-1:0]  cfg_pr,
  input  logic [IWDG_RLR_SIZE-1:0] cfg_rlr,
  input  logic [PERIOD_SIZE-1:0]   kick_period,
  input  logic                     kick_req,
  output logic [IWDG_KR_SIZE-1:0]  dat_m2s,
  output logic [31:0]              adr_m2s,
  output logic                     cyc_m2s,
  output logic                     stb_m2s,
  output logic                     we_m2s,
  input  logic [IWDG_KR_SIZE-1:0]  dat_s2m,
  input  logic                     ack_s2m,
  output logic                     running,
  output logic                     busy,
  output logic                     err
);

  localparam int                      TO_W       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0]         TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [IWDG_KR_SIZE-1:0] KEY_UNLOCK = IWDG_KR_SIZE'(16'h5555);
  localparam logic [IWDG_KR_SIZE-1:0] KEY_START  = IWDG_KR_SIZE'(16'hCCCC);
  localparam logic [IWDG_KR_SIZE-1:0] KEY_RELOAD = IWDG_KR_SIZE'(16'hAAAA);

  typedef enum logic [3:0] {
    ST_IDLE, ST_UNLOCK, ST_WR_PR, ST_WR_RLR, ST_VERIFY, ST_START, ST_RUN, ST_RELOAD, ST_ERROR
  } state_t;

  state_t                   r_state;
  logic [IWDG_PR_SIZE-1:0]  r_pr;
  logic [IWDG_RLR_SIZE-1:0] r_rlr;
  logic [PERIOD_SIZE-1:0]   r_timer;
  logic [TO_W-1:0]          r_to_cnt;
  logic                     r_pend;
  logic                     r_cyc, r_stb, r_we, r_busy, r_running, r_err;
  logic [31:0]              r_adr;
  logic [IWDG_KR_SIZE-1:0]  r_dat;

  logic [31:0]              w_adr;
  logic [IWDG_KR_SIZE-1:0]  w_dat;
  logic                     w_we;
  state_t                   w_next;
  logic                     w_expire;
  logic                     w_active;
  logic                     w_unused;

  assign w_unused = ^dat_s2m;
  assign w_active = (r_state != ST_IDLE) && (r_state != ST_ERROR);
  assign w_expire = (kick_period != '0) && (r_timer == '0);

  // Transaction issued by the current bus state; narrow fields are zero-extended.
  always_comb begin
    w_adr = IWDG_KR_ADR;
    w_dat = KEY_RELOAD;
    w_we  = 1'b1;
    case (r_state)
      ST_UNLOCK: w_dat = KEY_UNLOCK;
      ST_WR_PR:  begin w_adr = IWDG_PR_ADR;  w_dat = IWDG_KR_SIZE'(r_pr);  end
      ST_WR_RLR: begin w_adr = IWDG_RLR_ADR; w_dat = IWDG_KR_SIZE'(r_rlr); end
      ST_VERIFY: begin w_adr = IWDG_RLR_ADR; w_dat = '0; w_we = 1'b0; end
      ST_START:  w_dat = KEY_START;
      default:   ;
    endcase
  end

  always_comb begin
    w_next = ST_RUN;
    case (r_state)
      ST_UNLOCK: w_next = ST_WR_PR;
      ST_WR_PR:  w_next = ST_WR_RLR;
`ifdef IWDG_KICK_VERIFY_EN
      ST_WR_RLR: w_next = ST_VERIFY;
      ST_VERIFY: w_next = (dat_s2m[IWDG_RLR_SIZE-1:0] == r_rlr) ? ST_START : ST_ERROR;
`else
      ST_WR_RLR: w_next = ST_START;
`endif
      default:   w_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      r_state   <= ST_IDLE;
      r_pr      <= '0;
      r_rlr     <= '0;
      r_timer   <= '0;
      r_to_cnt  <= '0;
      r_pend    <= 1'b0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_running <= 1'b0;
      r_err     <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
    end else begin
      if (kick_req && w_active) r_pend <= 1'b1;
      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            r_pr     <= cfg_pr;
            r_rlr    <= cfg_rlr;
            r_err    <= 1'b0;
            r_pend   <= 1'b0;
            r_adr    <= IWDG_KR_ADR;
            r_dat    <= KEY_UNLOCK;
            r_we     <= 1'b1;
            r_cyc    <= 1'b1;
            r_stb    <= 1'b1;
            r_busy   <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= ST_UNLOCK;
          end
        end
        ST_RUN: begin
          if (r_pend || w_expire) begin
            // NOTE: this later non-blocking write overrides the set above, so a kick landing on
            // the issuing edge is absorbed by the refresh being issued.
            r_pend   <= 1'b0;
            r_adr    <= IWDG_KR_ADR;
            r_dat    <= KEY_RELOAD;
            r_we     <= 1'b1;
            r_cyc    <= 1'b1;
            r_stb    <= 1'b1;
            r_busy   <= 1'b1;
            r_to_cnt <= '0;
            r_state  <= ST_RELOAD;
          end else if (kick_period != '0) begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          if (!r_stb) begin
            // Strobe was low for at least one cycle since the last ack: start this state's access.
            r_adr    <= w_adr;
            r_dat    <= w_dat;
            r_we     <= w_we;
            r_cyc    <= 1'b1;
            r_stb    <= 1'b1;
            r_busy   <= 1'b1;
            r_to_cnt <= '0;
          end else if (ack_s2m) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= w_next;
            if (w_next == ST_RUN) begin
              r_running <= 1'b1;
              r_timer   <= kick_period - 1'b1;
            end
            if (w_next == ST_ERROR) begin
              r_err     <= 1'b1;
              r_running <= 1'b0;
              r_pend    <= 1'b0;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b1;
            r_running <= 1'b0;
            r_pend    <= 1'b0;
            r_state   <= ST_ERROR;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign dat_m2s = r_dat;
  assign adr_m2s = r_adr;
  assign cyc_m2s = r_cyc;
  assign stb_m2s = r_stb;
  assign we_m2s  = r_we;
  assign running = r_running;
  assign busy    = r_busy;
  assign err     = r_err;

endmodule

// File: tb/tb_iwdg_kick_master.sv
// Self-checking bench for iwdg_kick_master: Wishbone slave model, expected-transaction queue and
// a per-cycle protocol/status model; directed scenarios for bring-up, refresh, kicks, timeout, reset.
module tb_iwdg_kick_master;

  localparam int          KR_W   = 16;
  localparam int          PR_W   = 3;
  localparam int          RLR_W  = 12;
  localparam int          PER_W  = 16;
  localparam int          ACK_TO = 16;
  localparam logic [31:0] KR_A   = 32'h0100_0000;
  localparam logic [31:0] PR_A   = 32'h0100_0004;
  localparam logic [31:0] RLR_A  = 32'h0100_0008;
  localparam logic [31:0] NO_ADR = 32'hFFFF_FFFF;
`ifdef IWDG_KICK_VERIFY_EN
  localparam int BRINGUP_SPAN = 8;
`else
  localparam int BRINGUP_SPAN = 6;
`endif

  logic             clk_m2s = 1'b0;
  logic             rst_m2s = 1'b1;
  logic             start = 1'b0;
  logic             kick_req = 1'b0;
  logic [PR_W-1:0]  cfg_pr = '0;
  logic [RLR_W-1:0] cfg_rlr = '0;
  logic [PER_W-1:0] kick_period = '0;
  logic [KR_W-1:0]  dat_m2s;
  logic [31:0]      adr_m2s;
  logic             cyc_m2s, stb_m2s, we_m2s;
  logic [KR_W-1:0]  dat_s2m = '0;
  logic             ack_s2m = 1'b0;
  logic             running, busy, err;

  iwdg_kick_master dut (
    .clk_m2s(clk_m2s), .rst_m2s(rst_m2s), .start(start), .cfg_pr(cfg_pr), .cfg_rlr(cfg_rlr),
    .kick_period(kick_period), .kick_req(kick_req), .dat_m2s(dat_m2s), .adr_m2s(adr_m2s),
    .cyc_m2s(cyc_m2s), .stb_m2s(stb_m2s), .we_m2s(we_m2s), .dat_s2m(dat_s2m), .ack_s2m(ack_s2m),
    .running(running), .busy(busy), .err(err)
  );

  always #5 clk_m2s = ~clk_m2s;

  typedef struct {
    logic [31:0]     adr;
    logic [KR_W-1:0] dat;
    logic            we;
  } txn_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc_n = 0;
  txn_t exp_q[$];
  int   aaaa_t[$];
  int   first_t = 0;
  int   cccc_t = 0;

  // Slave behaviour knobs, set by the scenarios.
  int              ack_wait = 0;
  logic [31:0]     stall_adr = NO_ADR;
  logic [KR_W-1:0] rd_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Behavioural model state: what the master must be doing, derived from bus events.
  logic             s_rst, s_start, s_ack;
  logic [RLR_W-1:0] s_rlr;
  logic             m_active = 1'b0, m_running = 1'b0, m_err = 1'b0;
  logic [RLR_W-1:0] m_rlr = '0;
  int               stall = 0;
  int               wcnt = 0;
  logic             p_stb = 1'b0, p_we = 1'b0;
  logic [31:0]      p_adr = '0;
  logic [KR_W-1:0]  p_dat = '0;
  txn_t             hs;
  logic [KR_W-1:0]  hs_rd = '0;

  initial begin
    forever begin
      @(posedge clk_m2s);
      cyc_n++;
      s_rst = rst_m2s; s_start = start; s_ack = ack_s2m; s_rlr = cfg_rlr;
      @(negedge clk_m2s);
      if (s_rst) begin
        check("reset_outputs", {cyc_m2s, stb_m2s, busy, err, running}, 5'b0);
        m_active = 1'b0; m_running = 1'b0; m_err = 1'b0; stall = 0;
      end else begin
        if (p_stb && s_ack) begin
          check("stb_drop_after_ack", stb_m2s, 1'b0);
          stall = 0;
          if (hs.we && hs.adr == KR_A && hs.dat == 16'hCCCC) m_running = 1'b1;
          if (!hs.we && hs.adr == RLR_A && hs_rd[RLR_W-1:0] != m_rlr) begin
            m_err = 1'b1; m_active = 1'b0; m_running = 1'b0;
          end
        end else if (p_stb) begin
          stall++;
          if (stall == ACK_TO) begin
            check("timeout_drop", stb_m2s, 1'b0);
            m_err = 1'b1; m_active = 1'b0; m_running = 1'b0; stall = 0;
          end else begin
            check("stb_hold", stb_m2s, 1'b1);
            check("hold_stable", {adr_m2s, dat_m2s, we_m2s}, {p_adr, p_dat, p_we});
          end
        end
        if (!p_stb && stb_m2s) stall = 0;
        if (s_start && !m_active) begin
          check("start_latency", {stb_m2s, adr_m2s, dat_m2s, we_m2s}, {1'b1, KR_A, 16'h5555, 1'b1});
          m_active = 1'b1; m_err = 1'b0; m_running = 1'b0; m_rlr = s_rlr;
        end
        if (!m_active) check("quiet_when_inactive", stb_m2s, 1'b0);
      end
      check("err", err, m_err);
      check("running", running, m_running);
      check("cyc_busy_track_stb", {cyc_m2s, busy}, {stb_m2s, stb_m2s});
`ifndef IWDG_KICK_VERIFY_EN
      if (stb_m2s) check("we_always_write", we_m2s, 1'b1);
`endif
      p_stb = stb_m2s; p_adr = adr_m2s; p_dat = dat_m2s; p_we = we_m2s;

      // Slave: acknowledge after ack_wait cycles unless the address is being stalled.
      if (ack_s2m) begin
        ack_s2m = 1'b0; wcnt = 0;
      end else if (stb_m2s && !rst_m2s) begin
        if (adr_m2s != stall_adr && wcnt >= ack_wait) begin
          ack_s2m = 1'b1; wcnt = 0;
          dat_s2m = we_m2s ? '0 : rd_data;
          hs.adr = adr_m2s; hs.dat = dat_m2s; hs.we = we_m2s; hs_rd = dat_s2m;
          check("txn_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            txn_t e;
            e = exp_q.pop_front();
            check("txn_adr", adr_m2s, e.adr);
            check("txn_we", we_m2s, e.we);
            if (e.we) check("txn_dat", dat_m2s, e.dat);
          end
          if (we_m2s && adr_m2s == KR_A && dat_m2s == 16'h5555) first_t = cyc_n;
          if (we_m2s && adr_m2s == KR_A && dat_m2s == 16'hCCCC) cccc_t = cyc_n;
          if (we_m2s && adr_m2s == KR_A && dat_m2s == 16'hAAAA) aaaa_t.push_back(cyc_n);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_m2s);
  endtask

  task automatic do_reset();
    @(negedge clk_m2s);
    rst_m2s = 1'b1;
    exp_q.delete(); aaaa_t.delete();
    stall_adr = NO_ADR; ack_wait = 0;
    tick(2);
    rst_m2s = 1'b0;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_kick();
    kick_req = 1'b1; tick(1); kick_req = 1'b0; tick(1);
  endtask

  task automatic push(input logic [31:0] a, input logic [KR_W-1:0] d, input logic w);
    txn_t t;
    t.adr = a; t.dat = d; t.we = w;
    exp_q.push_back(t);
  endtask

  task automatic push_bringup(input logic [PR_W-1:0] pr, input logic [RLR_W-1:0] rlr, input bit to_start);
    push(KR_A, 16'h5555, 1'b1);
    push(PR_A, {13'b0, pr}, 1'b1);
    push(RLR_A, {4'b0, rlr}, 1'b1);
`ifdef IWDG_KICK_VERIFY_EN
    push(RLR_A, '0, 1'b0);
`endif
    if (to_start) push(KR_A, 16'hCCCC, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1); n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    // 1: bring-up with auto refresh off; a stray start while running is ignored.
    do_reset();
    check("reset_state", {cyc_m2s, stb_m2s, busy, err, running}, 5'b0);
    cfg_pr = 3'b001; cfg_rlr = 12'h001; kick_period = '0;
    push_bringup(3'b001, 12'h001, 1'b1);
    pulse_start();
    wait_drain(100);
    tick(2);
    check("t1_running", {running, err}, 2'b10);
    check("t1_bringup_span", cccc_t - first_t, BRINGUP_SPAN);
    pulse_start();
    tick(40);
    check("t1_no_more_traffic", exp_q.size(), 0);

    // 2: periodic refresh every kick_period+1 cycles.
    do_reset();
    cfg_pr = 3'b101; cfg_rlr = 12'h3A7; kick_period = 16'd20;
    push_bringup(3'b101, 12'h3A7, 1'b1);
    repeat (6) push(KR_A, 16'hAAAA, 1'b1);
    pulse_start();
    begin
      int n = 0;
      while (aaaa_t.size() < 6 && n < 400) begin tick(1); n++; end
    end
    kick_period = '0;
    tick(30);
    check("t2_kicks_seen", aaaa_t.size(), 6);
    check("queue_drained", exp_q.size(), 0);
    if (aaaa_t.size() >= 6) begin
      check("t2_first_kick_offset", aaaa_t[0] - cccc_t, 21);
      for (int i = 1; i < 6; i++) check("t2_kick_interval", aaaa_t[i] - aaaa_t[i-1], 21);
    end

    // 3: three kicks during bring-up collapse into one refresh right after RUN entry.
    do_reset();
    cfg_pr = 3'b010; cfg_rlr = 12'hFFF; kick_period = '0;
    push_bringup(3'b010, 12'hFFF, 1'b1);
    push(KR_A, 16'hAAAA, 1'b1);
    pulse_start();
    pulse_kick(); pulse_kick(); pulse_kick();
    wait_drain(100);
    tick(40);
    check("t3_single_kick", aaaa_t.size(), 1);
    check("queue_drained", exp_q.size(), 0);
    if (aaaa_t.size() >= 1) check("t3_kick_after_run", aaaa_t[0] - cccc_t, 2);

    // 4: ack withheld on the PR write -> timeout, ERROR; kick dropped; start recovers.
    do_reset();
    cfg_pr = 3'b011; cfg_rlr = 12'h010; kick_period = '0;
    stall_adr = PR_A;
    push(KR_A, 16'h5555, 1'b1);
    pulse_start();
    tick(ACK_TO + 10);
    check("t4_error_state", {stb_m2s, err, running}, 3'b010);
    check("queue_drained", exp_q.size(), 0);
    pulse_kick();
    tick(5);
    stall_adr = NO_ADR; ack_wait = 2;
    push_bringup(3'b011, 12'h010, 1'b1);
    pulse_start();
    wait_drain(150);
    tick(40);
    check("t4_recovered", {err, running}, 2'b01);
    check("t4_no_stale_kick", aaaa_t.size(), 0);

    // 5: reset while the RLR write is outstanding.
    do_reset();
    cfg_pr = 3'b111; cfg_rlr = 12'h555; kick_period = 16'd5;
    stall_adr = RLR_A;
    push(KR_A, 16'h5555, 1'b1);
    push(PR_A, 16'h0007, 1'b1);
    pulse_start();
    begin
      int n = 0;
      while (!(stb_m2s && adr_m2s == RLR_A) && n < 60) begin tick(1); n++; end
    end
    check("t5_rlr_reached", stb_m2s && adr_m2s == RLR_A, 1'b1);
    tick(3);
    rst_m2s = 1'b1;
    tick(1);
    check("t5_reset_drop", {cyc_m2s, stb_m2s, err, running}, 4'b0);
    rst_m2s = 1'b0;
    stall_adr = NO_ADR;
    tick(30);
    check("t5_quiet", {cyc_m2s, stb_m2s}, 2'b0);
    check("queue_drained", exp_q.size(), 0);

`ifdef IWDG_KICK_VERIFY_EN
    // 6: read-back mismatch aborts before the start key; a matching read-back starts normally.
    do_reset();
    cfg_pr = 3'b001; cfg_rlr = 12'h001; kick_period = '0;
    rd_data = 16'h0002;
    push_bringup(3'b001, 12'h001, 1'b0);
    pulse_start();
    wait_drain(100);
    tick(20);
    check("t6_verify_mismatch", {err, running}, 2'b10);
    rd_data = 16'h0001;
    push_bringup(3'b001, 12'h001, 1'b1);
    pulse_start();
    wait_drain(100);
    tick(5);
    check("t6_verify_match", {err, running}, 2'b01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
